cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle accumulator CPU control unit.
// Sequences instruction fetch, decode, operand access and accumulator write-back
// over a single request/acknowledge memory port.
//
// Memory handshake: mem_req rises together with mem_we/mem_addr, and all three hold
// steady until the cycle in which mem_ack=1 is sampled at a rising edge. That edge
// completes the transfer. mem_ack seen while mem_req=0 carries no meaning and is
// ignored. There is no timeout, so a request can wait forever.
module cpu_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic [15:0]       acc_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [3:0]        alu_op,
  output logic [15:0]       alu_operand,
  output logic              acc_alu_io_rw,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd7;
  localparam logic [3:0] OP_JGEZ  = 4'd8;
  localparam logic [3:0] OP_NOT   = 4'd9;

  state_t            state;
  logic [15:0]       ir;
  logic [15:0]       mdr;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc_inc;
  logic              jump_taken;
  logic [ADDR_W-1:0] pc_after_decode;
  logic              unused_ir_bits;

  assign opcode      = ir[15:12];
  assign operand     = ir[ADDR_W-1:0];
  assign mem_wdata   = acc_data;
  assign alu_operand = mdr;
  assign fsm_state   = state;

  // Bits between the operand field and the opcode carry no meaning.
  assign unused_ir_bits = ^ir[11:ADDR_W];

  // Next pc: sequential increment (wraps naturally) and branch resolution in DECODE.
  always_comb begin
    pc_inc          = pc + ADDR_W'(1);
    jump_taken      = 1'b0;
    if (opcode == OP_JMP) begin
      jump_taken = 1'b1;
    end else if (opcode == OP_JGEZ) begin
      jump_taken = ~acc_data[15];
    end
    pc_after_decode = jump_taken ? operand : pc;
  end

  // Control FSM with registered strobes; each transition sets up next-state outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= '0;
      ir            <= '0;
      mdr           <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      alu_op        <= '0;
      acc_alu_io_rw <= 1'b0;
      halted        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            pc       <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= '0;
          end
        end

        S_FETCH: begin
          if (mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc_inc;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (opcode)
            OP_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            OP_JMP, OP_JGEZ: begin
              pc       <= pc_after_decode;
              state    <= S_FETCH;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc_after_decode;
            end
            OP_NOT: begin
              state         <= S_WB;
              acc_alu_io_rw <= 1'b1;
              alu_op        <= opcode;
            end
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              state    <= S_EXEC;
              mem_req  <= 1'b1;
              mem_we   <= (opcode == OP_STORE);
              mem_addr <= operand;
            end
            default: begin
              // Unassigned opcodes behave as NOP.
              state    <= S_FETCH;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
            end
          endcase
        end

        S_EXEC: begin
          if (mem_ack) begin
            if (mem_we) begin
              // Store done: go straight to the next fetch without a bubble.
              state    <= S_FETCH;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
            end else begin
              mdr           <= mem_rdata;
              state         <= S_WB;
              mem_req       <= 1'b0;
              acc_alu_io_rw <= 1'b1;
              alu_op        <= opcode;
            end
          end
        end

        S_WB: begin
          acc_alu_io_rw <= 1'b0;
          alu_op        <= '0;
          state         <= S_FETCH;
          mem_req       <= 1'b1;
          mem_we        <= 1'b0;
          mem_addr      <= pc;
        end

        S_HALT: begin
          halted <= 1'b1;
        end

        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // An open request keeps its address and direction until it is acknowledged.
  property p_req_stable;
    @(posedge clk) disable iff (!rst_n)
      (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr) && $stable(mem_we));
  endproperty
  a_req_stable: assert property (p_req_stable);

  // The accumulator write strobe never lasts more than one cycle.
  property p_strobe_single;
    @(posedge clk) disable iff (!rst_n)
      acc_alu_io_rw |=> !acc_alu_io_rw;
  endproperty
  a_strobe_single: assert property (p_strobe_single);

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: randomized and directed programs run against an instruction-level
// reference model; bus and accumulator events are compared in order.
module tb_cpu_ctrl;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_rdata = '0;
  logic [15:0]   acc_data = '0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [3:0]    alu_op;
  logic [15:0]   alu_operand;
  logic          acc_alu_io_rw;
  logic [AW-1:0] pc;
  logic          halted;
  logic [2:0]    fsm_state;

  cpu_ctrl #(.ADDR_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .acc_data      (acc_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .alu_op        (alu_op),
    .alu_operand   (alu_operand),
    .acc_alu_io_rw (acc_alu_io_rw),
    .pc            (pc),
    .halted        (halted),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  // Event word: [31]=is_fetch, [29:28]=class (1 read, 2 write, 3 acc write),
  // [27:24]=alu op, [23:16]=address, [15:0]=data.
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  bit          exp_halt;
  logic [15:0] img[256];
  logic [15:0] mem[256];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_ev(input logic [1:0] cls, input logic [3:0] op,
                                        input logic [7:0] a, input logic [15:0] d,
                                        input bit is_fetch);
    return {is_fetch, 1'b0, cls, op, a, d};
  endfunction

  // Accumulator behaviour as the surrounding datapath defines it.
  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] acc,
                                      input logic [15:0] x);
    case (op)
      4'd1:    return x;
      4'd3:    return acc + x;
      4'd4:    return acc - x;
      4'd5:    return acc & x;
      4'd6:    return acc | x;
      4'd9:    return ~acc;
      default: return acc;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Interprets the program image instruction by instruction, producing the bus and
  // accumulator events in order plus the zero-wait cycle of each fetch.
  task automatic build_expect(input int max_instr);
    logic [15:0] m[256];
    logic [7:0]  mpc;
    logic [15:0] acc, mdr, ir;
    logic [3:0]  op;
    logic [7:0]  a;
    int          cyc;
    exp_q.delete();
    cyc_q.delete();
    exp_halt = 1'b0;
    for (int i = 0; i < 256; i++) m[i] = img[i];
    mpc = 8'h00; acc = '0; mdr = '0; cyc = 1;
    for (int n = 0; n < max_instr; n++) begin
      ir = m[mpc];
      exp_q.push_back(mk_ev(2'd1, 4'd0, mpc, ir, 1'b1));
      cyc_q.push_back(cyc);
      mpc = mpc + 8'd1;
      op  = ir[15:12];
      a   = ir[7:0];
      if (op == 4'd0) begin
        exp_halt = 1'b1;
        break;
      end
      case (op)
        4'd1, 4'd3, 4'd4, 4'd5, 4'd6: begin
          mdr = m[a];
          exp_q.push_back(mk_ev(2'd1, 4'd0, a, mdr, 1'b0));
          exp_q.push_back(mk_ev(2'd3, op, 8'h00, mdr, 1'b0));
          acc = alu(op, acc, mdr);
          cyc += 4;
        end
        4'd2: begin
          exp_q.push_back(mk_ev(2'd2, 4'd0, a, acc, 1'b0));
          m[a] = acc;
          cyc += 3;
        end
        4'd7: begin mpc = a; cyc += 2; end
        4'd8: begin if (!acc[15]) mpc = a; cyc += 2; end
        4'd9: begin
          exp_q.push_back(mk_ev(2'd3, op, 8'h00, mdr, 1'b0));
          acc = ~acc;
          cyc += 3;
        end
        default: cyc += 2;
      endcase
    end
  endtask

  task automatic compare_ev(input string tag, input logic [31:0] got, output bit was_fetch);
    logic [31:0] e;
    was_fetch = 1'b0;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_unexpected"}, got, 32'h0);
    end else begin
      e = exp_q.pop_front();
      was_fetch = e[31];
      check_eq(tag, {2'b00, got[29:0]}, {2'b00, e[29:0]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; acc_data = '0;
    #1;
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_strobe", acc_alu_io_rw, 1'b0);
    check_eq("rst_alu_op", alu_op, 4'd0);
    check_eq("rst_halted", halted, 1'b0);
    check_eq("rst_pc", pc, 8'h00);
    check_eq("rst_operand", alu_operand, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // wait_mode: 0 zero-wait, 1 random waits with spurious acks and start noise,
  // 2 every request held off for 5 cycles.
  task automatic run_prog(input int wait_mode, input int max_instr, input int budget);
    int          cyc, wl;
    bit          in_txn, pc_chk, was_fetch;
    logic [7:0]  t_addr, pc_exp;
    logic [7:0]  t_pc;
    logic        t_we;
    logic [31:0] ev;
    build_expect(max_instr);
    for (int i = 0; i < 256; i++) mem[i] = img[i];
    do_reset();
    @(negedge clk);
    start = 1'b1;
    cyc = 0; wl = 0; in_txn = 1'b0; pc_chk = 1'b0;
    t_addr = '0; t_pc = '0; t_we = 1'b0; pc_exp = '0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (wait_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (pc_chk) begin
        check_eq("pc_after_fetch", pc, pc_exp);
        pc_chk = 1'b0;
      end
      if (acc_alu_io_rw) begin
        compare_ev("acc_write", mk_ev(2'd3, alu_op, 8'h00, alu_operand, 1'b0), was_fetch);
        acc_data = alu(alu_op, acc_data, alu_operand);
      end else begin
        check_eq("alu_op_idle", alu_op, 4'd0);
      end
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);
      if (mem_req) begin
        if (!in_txn) begin
          in_txn = 1'b1; t_addr = mem_addr; t_we = mem_we; t_pc = pc;
          wl = (wait_mode == 0) ? 0 : (wait_mode == 1) ? int'($urandom_range(0, 3)) : 5;
        end else begin
          check_eq("req_addr_stable", mem_addr, t_addr);
          check_eq("req_we_stable", mem_we, t_we);
          check_eq("pc_stable_in_wait", pc, t_pc);
        end
        if (wl == 0) begin
          mem_ack = 1'b1;
          in_txn  = 1'b0;
          if (mem_we) begin
            ev = mk_ev(2'd2, 4'd0, mem_addr, mem_wdata, 1'b0);
            mem[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr];
            ev = mk_ev(2'd1, 4'd0, mem_addr, mem_rdata, 1'b0);
          end
          compare_ev(mem_we ? "mem_write" : "mem_read", ev, was_fetch);
          if (was_fetch) begin
            pc_chk = 1'b1;
            pc_exp = mem_addr + 8'd1;
            if (cyc_q.size() > 0) begin
              if (wait_mode == 0) check_eq("fetch_cycle", cyc, cyc_q.pop_front());
              else void'(cyc_q.pop_front());
            end
          end
        end else begin
          wl--;
        end
      end else begin
        if (in_txn) begin
          check_eq("req_held_until_ack", mem_req, 1'b1);
          in_txn = 1'b0;
        end
        if (wait_mode == 1 && $urandom_range(0, 4) == 0) mem_ack = 1'b1;
      end
    end
    if (exp_q.size() > 0) check_eq("events_left_at_budget", exp_q.size(), 0);
    @(negedge clk);
    mem_ack = 1'b0; start = 1'b0;
    if (pc_chk) check_eq("pc_after_fetch", pc, pc_exp);
    @(negedge clk);
    if (exp_halt) begin
      check_eq("halted_timing", halted, 1'b1);
      start = 1'b1; mem_ack = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0; mem_ack = 1'b0;
      check_eq("halt_sticky", halted, 1'b1);
      check_eq("halt_no_req", mem_req, 1'b0);
      check_eq("halt_no_strobe", acc_alu_io_rw, 1'b0);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  task automatic gen_random_prog(input int len);
    logic [3:0] op;
    logic [7:0] a;
    clear_img();
    for (int i = 0; i < len; i++) begin
      op = 4'($urandom_range(1, 15));
      if (op == 4'd7 || op == 4'd8) a = 8'($urandom_range(i + 1, len));
      else a = 8'h80 + 8'($urandom_range(0, 15));
      img[i] = {op, 4'($urandom_range(0, 15)), a};
    end
    img[len] = 16'h0000;
    for (int k = 0; k < 16; k++) img[8'h80 + k] = 16'($urandom);
  endtask

  // Abandon a data read while it waits, then confirm a clean restart from address 0.
  task automatic reset_mid_exec();
    clear_img();
    img[0] = 16'h1010; img[8'h10] = 16'h0005;
    for (int i = 0; i < 256; i++) mem[i] = img[i];
    do_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    mem_ack = 1'b1; mem_rdata = mem[0];
    @(negedge clk); mem_ack = 1'b0;
    @(negedge clk);
    check_eq("exec_req_open", mem_req, 1'b1);
    check_eq("exec_req_addr", mem_addr, 8'h10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", mem_req, 1'b0);
    check_eq("mid_rst_pc", pc, 8'h00);
    check_eq("mid_rst_we", mem_we, 1'b0);
    check_eq("mid_rst_strobe", acc_alu_io_rw, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("refetch_req", mem_req, 1'b1);
    check_eq("refetch_addr", mem_addr, 8'h00);
    check_eq("refetch_pc", pc, 8'h00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // LOAD 0x10, ADD 0x11, STORE 0x12, HALT
    clear_img();
    img[0] = 16'h1010; img[1] = 16'h3011; img[2] = 16'h2012; img[3] = 16'h0000;
    img[8'h10] = 16'd5; img[8'h11] = 16'd3;
    run_prog(0, 64, 200);
    run_prog(2, 64, 400);

    // JGEZ not taken on negative acc, taken on positive acc
    clear_img();
    img[0] = 16'h1080; img[1] = 16'h8020; img[2] = 16'h1081; img[3] = 16'h8020;
    img[8'h80] = 16'h8000; img[8'h81] = 16'h0001;
    run_prog(0, 64, 200);

    // pc wrap: JMP 0xFF, NOP at 0xFF falls through to 0x00
    clear_img();
    img[0] = 16'h70FF; img[8'hFF] = 16'hA000;
    run_prog(0, 4, 100);

    // NOT uses the operand register, plus a STORE of the complement
    clear_img();
    img[0] = 16'h1040; img[1] = 16'h9000; img[2] = 16'h2041; img[3] = 16'h0000;
    img[8'h40] = 16'h00F0;
    run_prog(1, 64, 400);

    reset_mid_exec();

    for (int r = 0; r < 24; r++) begin
      gen_random_prog($urandom_range(8, 40));
      run_prog(r % 3, 200, 4000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
